// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if
//   Groups the bus signals around the fetch stage: the pipelined
//   instruction-memory port, the redirect request and the instruction
//   valid/ready handshake toward the datapath.
//
//   master : the fetch unit (drives imem_req/imem_addr and the instruction
//            output side; receives grant/response, redirect and instr_ready).
//   slave  : the environment (memory, branch/trap logic, datapath).
//
//   imem_req     fetch request valid
//   imem_addr    word-aligned fetch address
//   imem_gnt     request accepted this cycle
//   imem_rvalid  read data valid (in order, >= 1 cycle after grant)
//   imem_rdata   instruction word
//   redirect     flush and restart fetch
//   redirect_pc  restart address (bits [1:0] ignored)
//   instr_valid  head of prefetch FIFO is valid
//   instr        head instruction (0 when empty)
//   pc           address of head instruction (0 when empty)
//   instr_ready  consumer accepts head
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage in front of the single-cycle datapath. Owns the fetch PC,
//   issues in-order requests on a pipelined instruction-memory port, buffers
//   returned words with their addresses in a DEPTH-entry prefetch FIFO and
//   presents the head through a valid/ready handshake. A redirect flushes the
//   FIFO, marks every in-flight response for discard and restarts fetch.
//
//   Parameters: RESET_PC (fetch address after reset), DEPTH (FIFO entries,
//   power of two >= 2, also the bound on outstanding requests).
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    instr_fetch_unit_if.master (memory port, redirect, instr output)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;

  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  cnt_t        count;
  cnt_t        outstanding;
  cnt_t        discard;
  ptr_t        rd_ptr;
  ptr_t        wr_ptr;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic [CW:0] occupancy;
  logic        req;
  logic        grant;
  logic        rsp;
  logic        drop;
  logic        push;
  logic        pop;
  logic        head_valid;
  cnt_t        outstanding_nxt;
  logic [31:0] redirect_target;

  always_comb begin
    occupancy       = {1'b0, count} + {1'b0, outstanding};
    // Requests are reserved against FIFO space up front, so a returning word
    // always has a slot; reset gating keeps imem_req low while reset is held.
    req             = reset && !bus.redirect && (occupancy < (CW+1)'(DEPTH));
    grant           = req && bus.imem_gnt;
    rsp             = bus.imem_rvalid;
    drop            = rsp && (discard != '0);
    head_valid      = (count != '0);
    push            = rsp && (discard == '0) && !bus.redirect;
    pop             = head_valid && bus.instr_ready && !bus.redirect;
    outstanding_nxt = outstanding + cnt_t'(grant) - cnt_t'(rsp);
    redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (bus.redirect) begin
        // Everything still in flight after this cycle's accounting belongs to
        // the old path and must be dropped when it returns.
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        discard  <= outstanding_nxt;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (drop) begin
          discard <= discard - cnt_t'(1);
        end
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + ptr_t'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + ptr_t'(1);
        end
        count <= count + cnt_t'(push) - cnt_t'(pop);
      end
    end
  end

  // Storage has no reset; entries are only observable while count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= bus.imem_rdata;
      pc_mem[wr_ptr]    <= resp_pc;
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_valid ? instr_mem[rd_ptr] : '0;
  assign bus.pc          = head_valid ? pc_mem[rd_ptr]    : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Self-checking bench for instr_fetch_unit. A memory model answers granted
//   requests in order after a configurable latency; a reference model tags
//   each request with the redirect epoch it was issued in, keeps the expected
//   FIFO contents as a queue of addresses and the expected in-order pc stream.
module tb_instr_fetch_unit;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // ---------------- reference model / memory model state ----------------
  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } flight_t;

  flight_t     inflight[$];
  logic [31:0] fifo_q[$];
  int unsigned epoch = 0;
  int unsigned cyc   = 0;
  logic [31:0] exp_fetch;
  logic [31:0] exp_seq;

  int unsigned gnt_pct, rv_pct, ready_pct, redir_pct, max_lat;
  bit          force_redir = 1'b0;
  logic [31:0] force_pc;

  bit          c_req, c_gnt, c_rv, c_pop, c_redir;
  logic [31:0] c_addr, c_pc, c_instr, c_target;

  task automatic model_clear();
    inflight.delete();
    fifo_q.delete();
    epoch++;
    exp_fetch = RESET_PC;
    exp_seq   = RESET_PC;
  endtask

  // One clock cycle: drive at negedge, sample just before the rising edge,
  // advance the model on the edge, compare outputs at the following negedge.
  task automatic cycle();
    flight_t head;
    flight_t nf;
    bit      exp_req;
    bus.imem_gnt = ($urandom_range(99) < gnt_pct);
    if (inflight.size() != 0 && inflight[0].due <= cyc && $urandom_range(99) < rv_pct) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = data_of(inflight[0].addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
    bus.instr_ready = ($urandom_range(99) < ready_pct);
    bus.redirect    = force_redir || ($urandom_range(99) < redir_pct);
    bus.redirect_pc = force_redir ? force_pc : $urandom;
    force_redir     = 1'b0;
    #1;
    c_req    = bus.imem_req;
    c_addr   = bus.imem_addr;
    c_gnt    = bus.imem_req && bus.imem_gnt;
    c_rv     = bus.imem_rvalid;
    c_pop    = bus.instr_valid && bus.instr_ready;
    c_pc     = bus.pc;
    c_instr  = bus.instr;
    c_redir  = bus.redirect;
    c_target = bus.redirect_pc;
    exp_req  = !c_redir && (fifo_q.size() + inflight.size() < DEPTH);
    chk("imem_req", 32'(c_req), 32'(exp_req));
    if (c_req) chk("imem_addr", c_addr, exp_fetch);
    chk("occupancy_le_depth", 32'(fifo_q.size() + inflight.size() <= DEPTH), 32'd1);
    @(posedge clk);
    if (c_rv && inflight.size() != 0) begin
      head = inflight.pop_front();
      if (head.epoch == epoch && !c_redir) fifo_q.push_back(head.addr);
    end
    if (c_pop && !c_redir) begin
      chk("pop_pc_order", c_pc, exp_seq);
      chk("pop_instr", c_instr, data_of(exp_seq));
      exp_seq = exp_seq + 32'd4;
      void'(fifo_q.pop_front());
    end
    if (c_gnt) begin
      nf.addr  = c_addr;
      nf.epoch = epoch;
      nf.due   = cyc + 1 + $urandom_range(max_lat);
      inflight.push_back(nf);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (c_redir) begin
      fifo_q.delete();
      epoch++;
      exp_fetch = c_target & 32'hFFFF_FFFC;
      exp_seq   = exp_fetch;
    end
    cyc++;
    @(negedge clk);
    chk("instr_valid", 32'(bus.instr_valid), 32'(fifo_q.size() != 0));
    chk("pc", bus.pc, (fifo_q.size() != 0) ? fifo_q[0] : 32'h0);
    chk("instr", bus.instr, (fifo_q.size() != 0) ? data_of(fifo_q[0]) : 32'h0);
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    repeat (2) @(negedge clk);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc", bus.pc, 32'h0);
    model_clear();
    reset = 1'b1;
  endtask

  task automatic knobs(input int unsigned g, input int unsigned r, input int unsigned rd,
                       input int unsigned rr, input int unsigned l);
    gnt_pct = g; rv_pct = r; ready_pct = rd; redir_pct = rr; max_lat = l;
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_first;
    logic [31:0] exp_second;
  } redir_vec_t;

  typedef struct {
    int unsigned gnt, rv, ready, redir, lat;
  } seg_t;

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    redir_vec_t vecs[5];
    seg_t       segs[4];
    int         n;
    bit         seen;

    vecs[0] = '{32'h0000_0102, 32'h0000_0100, 32'h0000_0104};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[2] = '{32'h1234_5673, 32'h1234_5670, 32'h1234_5674};
    vecs[3] = '{32'h0000_0003, 32'h0000_0000, 32'h0000_0004};
    vecs[4] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0004};

    segs[0] = '{100, 100, 70, 2, 0};
    segs[1] = '{60, 60, 50, 3, 3};
    segs[2] = '{90, 40, 90, 1, 2};
    segs[3] = '{40, 90, 30, 5, 1};

    // ---- zero-wait stream after reset ----
    do_reset();
    knobs(100, 100, 100, 0, 0);
    cycle();
    chk("first_req", 32'(c_req), 32'd1);
    chk("first_addr", c_addr, RESET_PC);
    chk("fill_valid_c1", 32'(bus.instr_valid), 32'd0);
    cycle();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_valid) n++;
      cycle();
    end
    chk("stream_one_per_cycle", n, 20);

    // ---- consumer stall ----
    do_reset();
    knobs(100, 100, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n += int'(c_gnt);
    end
    chk("stall_grants", n, 4);
    chk("stall_req_low", 32'(bus.imem_req), 32'd0);
    ready_pct = 100;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n += int'(c_pop);
      chk("release_pc", c_pc, 32'(i * 4));
      if (i == 0) chk("release_req_c0", 32'(c_req), 32'd0);
      if (i == 1) chk("release_req_c1", 32'(c_req), 32'd1);
    end
    chk("release_pops", n, 4);

    // ---- redirect with three requests outstanding ----
    do_reset();
    knobs(100, 0, 100, 0, 0);
    n = 0;
    for (int k = 0; k < 10 && n < 3; k++) begin
      cycle();
      n += int'(c_gnt);
    end
    chk("three_outstanding", n, 3);
    gnt_pct     = 0;
    force_redir = 1'b1;
    force_pc    = 32'h0000_0102;
    cycle();
    chk("redir_req_low", 32'(c_req), 32'd0);
    knobs(100, 100, 100, 0, 0);
    cycle();
    chk("post_redir_req", 32'(c_req), 32'd1);
    chk("post_redir_addr", c_addr, 32'h0000_0100);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.instr_valid) seen = 1'b1;
      else cycle();
    end
    chk("redir3_seen", 32'(seen), 32'd1);
    chk("redir3_first_pc", bus.pc, 32'h0000_0100);

    // ---- redirect coinciding with a response (grant is blocked) ----
    for (int i = 0; i < 5; i++) cycle();
    force_redir = 1'b1;
    force_pc    = 32'h0000_4000;
    cycle();
    chk("coinc_rvalid", 32'(c_rv), 32'd1);
    chk("coinc_req_low", 32'(c_req), 32'd0);
    cycle();
    chk("coinc_next_req", 32'(c_req), 32'd1);
    chk("coinc_next_addr", c_addr, 32'h0000_4000);

    // ---- table-driven redirect targets (alignment and wrap) ----
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 3; i++) cycle();
      force_redir = 1'b1;
      force_pc    = vecs[v].target;
      cycle();
      n = 0;
      while (!bus.instr_valid && n < 10) begin
        cycle();
        n++;
      end
      chk("vec_latency", n, 2);
      chk("vec_first_pc", bus.pc, vecs[v].exp_first);
      chk("vec_first_instr", bus.instr, data_of(vecs[v].exp_first));
      cycle();
      chk("vec_second_pc", bus.pc, vecs[v].exp_second);
    end

    // ---- randomized segments against the model ----
    do_reset();
    for (int s = 0; s < 4; s++) begin
      knobs(segs[s].gnt, segs[s].rv, segs[s].ready, segs[s].redir, segs[s].lat);
      for (int i = 0; i < 800; i++) cycle();
    end

    // ---- reset mid-stream with requests in flight ----
    knobs(100, 100, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle();
    chk("mid_has_inflight", 32'(inflight.size() != 0), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
    chk("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("mid_rst_instr", bus.instr, 32'h0);
    chk("mid_rst_pc", bus.pc, 32'h0);
    @(negedge clk);
    do_reset();
    knobs(100, 100, 100, 0, 0);
    cycle();
    chk("mid_first_req", 32'(c_req), 32'd1);
    chk("mid_first_addr", c_addr, RESET_PC);
    for (int i = 0; i < 6; i++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
